ps2_key_decoder: RTL

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder.sv | 102 ++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 decoder for the spacebar and the left/right arrow keys.
// It produces held-key levels and a pulse when a prefix sequence is abandoned.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYC = 130000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       key_space,
  output logic       key_left,
  output logic       key_right,
  output logic       seq_error
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT_CYC);

  localparam logic [7:0] C_EXT   = 8'hE0;
  localparam logic [7:0] C_BRK   = 8'hF0;
  localparam logic [7:0] C_SPACE = 8'h29;
  localparam logic [7:0] C_LEFT  = 8'h6B;
  localparam logic [7:0] C_RIGHT = 8'h74;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t        r_state, w_stateNext;
  logic [CW-1:0] r_cnt, w_cntNext;
  logic          r_keySpace, r_keyLeft, r_keyRight, r_seqError;
  logic          w_keySpaceNext, w_keyLeftNext, w_keyRightNext, w_seqErrorNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_keySpace <= 1'b0;
      r_keyLeft  <= 1'b0;
      r_keyRight <= 1'b0;
      r_seqError <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_cnt      <= w_cntNext;
      r_keySpace <= w_keySpaceNext;
      r_keyLeft  <= w_keyLeftNext;
      r_keyRight <= w_keyRightNext;
      r_seqError <= w_seqErrorNext;
    end
  end

  // An accepted byte always wins over the timeout; any byte not continuing a prefix lands in IDLE.
  always_comb begin
    w_stateNext    = r_state;
    w_cntNext      = r_cnt;
    w_keySpaceNext = r_keySpace;
    w_keyLeftNext  = r_keyLeft;
    w_keyRightNext = r_keyRight;
    w_seqErrorNext = 1'b0;

    if (rx_valid) begin
      w_cntNext   = '0;
      w_stateNext = IDLE;
      unique case (r_state)
        IDLE: begin
          if (rx_data == C_EXT)        w_stateNext = EXT;
          else if (rx_data == C_BRK)   w_stateNext = BRK;
          else if (rx_data == C_SPACE) w_keySpaceNext = 1'b1;
        end
        EXT: begin
          if (rx_data == C_BRK)        w_stateNext = EXT_BRK;
          else if (rx_data == C_EXT)   w_stateNext = EXT;
          else if (rx_data == C_LEFT)  w_keyLeftNext = 1'b1;
          else if (rx_data == C_RIGHT) w_keyRightNext = 1'b1;
        end
        BRK: begin
          if (rx_data == C_BRK)        w_stateNext = BRK;
          else if (rx_data == C_SPACE) w_keySpaceNext = 1'b0;
        end
        EXT_BRK: begin
          if (rx_data == C_LEFT)       w_keyLeftNext = 1'b0;
          else if (rx_data == C_RIGHT) w_keyRightNext = 1'b0;
        end
        default: w_stateNext = IDLE;
      endcase
    end else if (r_state != IDLE) begin
      if (r_cnt >= C_TIMEOUT) begin
        w_stateNext    = IDLE;
        w_cntNext      = '0;
        w_seqErrorNext = 1'b1;
      end else begin
        w_cntNext = r_cnt + CW'(1);
      end
    end else begin
      w_cntNext = '0;
    end
  end

  assign key_space = r_keySpace;
  assign key_left  = r_keyLeft;
  assign key_right = r_keyRight;
  assign seq_error = r_seqError;

endmodule
